// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
// Holds the default datapath width, the ALU function codes, the execute
// FSM state encoding and small overflow helper functions.
package ex_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_NOT = 4'b0100;
  localparam logic [3:0] FN_SRA = 4'b1000;
  localparam logic [3:0] FN_SRL = 4'b1001;
  localparam logic [3:0] FN_SLL = 4'b1010;
  localparam logic [3:0] FN_ROL = 4'b1100;
  localparam logic [3:0] FN_ROR = 4'b1101;
  localparam logic [3:0] FN_MUL = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Signed overflow of A+B from the sign bits of A, B and the result.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of A-B from the sign bits of A, B and the result.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/ex_seq_mul.sv
// ex_seq_mul: iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (aborts a running multiply)
//   start       latch operands and begin (only asserted while not busy)
//   mcand       multiplicand A
//   mplier      multiplier B
//   busy        iterations in progress
//   done        final iteration is happening this cycle; product is complete
//   cnt         iteration counter (0..WIDTH-1)
//   product     acc plus the final partial product; valid while done is high
// ACC_W is WIDTH for a truncated product or 2*WIDTH for the full product.
module ex_seq_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic [ACC_W-1:0] product
);

  logic [ACC_W-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [ACC_W-1:0] acc_next_s;

  // Accumulator value after the current iteration's conditional add.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Operand latch and one shift-add step per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {ACC_W{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= ACC_W'(mcand);
      mplier_r <= mplier;
      acc_r    <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (cnt_r == CNT_W'(WIDTH-1)) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (cnt_r == CNT_W'(WIDTH-1));
  assign cnt     = cnt_r;
  assign product = acc_next_s;

endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: MIPS execute stage. Single-cycle ALU ops register their
// result at the accept edge; MUL runs on ex_seq_mul for WIDTH cycles with
// busy held high, then presents the low WIDTH product bits.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     operands/function present (accepted when !busy)
//   alu_func     operation code (see ex_pkg FN_*)
//   rf_a, rf_b   register operands A and B
//   immed        extended immediate, used as B when alu_bin_sel = 1
//   busy         multiply in progress, upstream must hold
//   out_valid    one-cycle pulse per new result
//   alu_out      registered result (memory stage address / write-back data)
//   zero         registered alu_out == 0
//   ovf          (only with EX_ALU_STAGE_OVF_EN) registered overflow flag
// Build option: define EX_ALU_STAGE_OVF_EN to add the ovf port and a
// full-width (2*WIDTH) multiply accumulator.
module ex_alu_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  input  logic [WIDTH-1:0] immed,
  input  logic             alu_bin_sel,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
`ifdef EX_ALU_STAGE_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

`ifdef EX_ALU_STAGE_OVF_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  state_t             state_r;
  logic               busy_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   alu_out_r;
  logic               zero_r;

  logic [WIDTH-1:0]   b_s;
  logic [4:0]         shamt_s;
  logic               accept_s;
  logic               mul_start_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic [2*WIDTH-1:0] rot_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [CNT_W-1:0]   mul_cnt_s;
  logic [ACC_W-1:0]   mul_prod_s;

  assign b_s         = alu_bin_sel ? immed : rf_b;
  assign shamt_s     = b_s[4:0];
  assign accept_s    = in_valid && !busy_r;
  assign mul_start_s = accept_s && (alu_func == FN_MUL);

  // Combinational ALU for the single-cycle ops; MUL comes from ex_seq_mul.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    rot_s     = {(2*WIDTH){1'b0}};
    case (alu_func)
      FN_ADD: alu_res_s = rf_a + b_s;
      FN_SUB: alu_res_s = rf_a - b_s;
      FN_AND: alu_res_s = rf_a & b_s;
      FN_OR:  alu_res_s = rf_a | b_s;
      FN_NOT: alu_res_s = ~rf_a;
      FN_SRA: alu_res_s = WIDTH'($signed(rf_a) >>> shamt_s);
      FN_SRL: alu_res_s = rf_a >> shamt_s;
      FN_SLL: alu_res_s = rf_a << shamt_s;
      // Rotates shift a doubled copy so a zero amount needs no special case.
      FN_ROL: begin
        rot_s     = {rf_a, rf_a} << shamt_s;
        alu_res_s = rot_s[2*WIDTH-1:WIDTH];
      end
      FN_ROR: begin
        rot_s     = {rf_a, rf_a} >> shamt_s;
        alu_res_s = rot_s[WIDTH-1:0];
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef EX_ALU_STAGE_OVF_EN
  logic ovf_r;
  logic ovf_s;

  // Overflow flag for the single-cycle ops (only add/sub can overflow).
  always_comb begin
    ovf_s = 1'b0;
    case (alu_func)
      FN_ADD:  ovf_s = add_ovf(rf_a[WIDTH-1], b_s[WIDTH-1], alu_res_s[WIDTH-1]);
      FN_SUB:  ovf_s = sub_ovf(rf_a[WIDTH-1], b_s[WIDTH-1], alu_res_s[WIDTH-1]);
      default: ovf_s = 1'b0;
    endcase
  end
`endif

  ex_seq_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .mcand   (rf_a),
    .mplier  (b_s),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .cnt     (mul_cnt_s),
    .product (mul_prod_s)
  );

  // Execute FSM and output registers. DONE is the multiplier's final
  // iteration cycle, so the product lands in alu_out as busy drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      alu_out_r   <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
`ifdef EX_ALU_STAGE_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mul_start_s) begin
            state_r     <= ST_MUL;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end else if (accept_s) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b1;
            alu_out_r   <= alu_res_s;
            zero_r      <= (alu_res_s == {WIDTH{1'b0}});
`ifdef EX_ALU_STAGE_OVF_EN
            ovf_r       <= ovf_s;
`endif
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        ST_MUL: begin
          out_valid_r <= 1'b0;
          // Counter steps to WIDTH-1 at this edge; the next cycle is the last.
          if (mul_busy_s && (mul_cnt_s == CNT_W'(WIDTH-2))) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_MUL;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          if (mul_done_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= mul_prod_s[WIDTH-1:0];
            zero_r      <= (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
`ifdef EX_ALU_STAGE_OVF_EN
            ovf_r       <= |mul_prod_s[2*WIDTH-1:WIDTH];
`endif
          end else begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign alu_out   = alu_out_r;
  assign zero      = zero_r;
`ifdef EX_ALU_STAGE_OVF_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed self-checking bench for ex_alu_stage.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  alu_func;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic [31:0] immed;
  logic        alu_bin_sel;
  logic        busy;
  logic        out_valid;
  logic [31:0] alu_out;
  logic        zero;
`ifdef EX_ALU_STAGE_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_alu_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .alu_func    (alu_func),
    .rf_a        (rf_a),
    .rf_b        (rf_b),
    .immed       (immed),
    .alu_bin_sel (alu_bin_sel),
    .busy        (busy),
    .out_valid   (out_valid),
    .alu_out     (alu_out),
`ifdef EX_ALU_STAGE_OVF_EN
    .ovf         (ovf),
`endif
    .zero        (zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef EX_ALU_STAGE_OVF_EN
    check_eq(tag, {31'd0, ovf}, {31'd0, exp});
`endif
  endtask

  task automatic drive(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic sel);
    in_valid    = 1'b1;
    alu_func    = fn;
    rf_a        = a;
    rf_b        = b;
    immed       = im;
    alu_bin_sel = sel;
  endtask

  // Issue one op at the falling edge, let it be accepted, return at the next falling edge.
  task automatic issue(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic sel);
    drive(fn, a, b, im, sel);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a MUL result, counting busy cycles; optionally poke in_valid while busy.
  task automatic wait_mul(output int busy_cnt, input bit poke, input logic [31:0] hold);
    busy_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (poke && k == 10) check_eq("mul_hold_prev", alu_out, hold);
      if (poke && (k == 5 || k == 20)) drive(4'b0000, 32'd1, 32'd1, 32'd0, 1'b0);
      else in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] exp;
    logic        eovf;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int bc;
    int stray;

    vecs[0]  = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h00F0_1234, 1'b0};
    vecs[1]  = '{4'b0011, 32'hF000_0000, 32'h0000_000F, 1'b1, 32'hF000_000F, 1'b0};
    vecs[2]  = '{4'b0100, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_0000, 1'b0};
    vecs[3]  = '{4'b1001, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000, 1'b0};
    vecs[4]  = '{4'b1010, 32'h0000_0001, 32'h0000_001F, 1'b1, 32'h8000_0000, 1'b0};
    vecs[5]  = '{4'b1100, 32'h8000_0001, 32'h0000_0004, 1'b0, 32'h0000_0018, 1'b0};
    vecs[6]  = '{4'b1101, 32'h8000_0001, 32'h0000_0004, 1'b0, 32'h1800_0001 & 32'h1800_0000, 1'b0};
    vecs[7]  = '{4'b1101, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0};
    vecs[8]  = '{4'b1010, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{4'b0111, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0};
    vecs[10] = '{4'b0001, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; alu_func = 4'd0;
    rf_a = 32'd0; rf_b = 32'd0; immed = 32'd0; alu_bin_sel = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_alu_out", alu_out, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_ovf("rst_ovf", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // add with immediate, signed overflow into the sign bit
    issue(4'b0000, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1);
    check_eq("add_imm", alu_out, 32'h8000_0000);
    check_eq("add_zero", {31'd0, zero}, 32'd0);
    check_eq("add_valid", {31'd0, out_valid}, 32'd1);
    check_ovf("add_ovf", 1'b1);
    @(negedge clk);
    check_eq("add_valid_fall", {31'd0, out_valid}, 32'd0);
    check_eq("add_hold", alu_out, 32'h8000_0000);

    // back-to-back sub then sra
    drive(4'b0001, 32'd5, 32'd5, 32'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    check_eq("sub_res", alu_out, 32'd0);
    check_eq("sub_zero", {31'd0, zero}, 32'd1);
    check_eq("sub_valid", {31'd0, out_valid}, 32'd1);
    drive(4'b1000, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("sra_res", alu_out, 32'hF800_0000);
    check_eq("sra_zero", {31'd0, zero}, 32'd0);
    check_eq("sra_valid_b2b", {31'd0, out_valid}, 32'd1);

    // add wraps to zero
    issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    check_eq("add_wrap", alu_out, 32'd0);
    check_eq("add_wrap_zero", {31'd0, zero}, 32'd1);
    check_ovf("add_wrap_ovf", 1'b0);

    // table of single-cycle ops, issued back to back
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].fn, vecs[i].a, vecs[i].sel ? 32'h5A5A_5A5A : vecs[i].b,
            vecs[i].sel ? vecs[i].b : 32'h5A5A_5A5A, vecs[i].sel);
      @(posedge clk); @(negedge clk);
      check_eq($sformatf("vec%0d_res", i), alu_out, vecs[i].exp);
      check_eq($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp == 32'd0});
      check_eq($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_ovf($sformatf("vec%0d_ovf", i), vecs[i].eovf);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // multiply with ignored in_valid pulses during busy
    issue(4'b1110, 32'h0001_0003, 32'h0000_0007, 32'd0, 1'b0);
    check_eq("mul_busy_start", {31'd0, busy}, 32'd1);
    check_eq("mul_no_valid_start", {31'd0, out_valid}, 32'd0);
    wait_mul(bc, 1'b1, 32'h7FFF_FFFF);
    check_eq("mul_busy_cycles", bc, 32'd32);
    check_eq("mul_valid", {31'd0, out_valid}, 32'd1);
    check_eq("mul_busy_end", {31'd0, busy}, 32'd0);
    check_eq("mul_res", alu_out, 32'h0007_0015);
    check_ovf("mul_ovf0", 1'b0);
    @(negedge clk);
    check_eq("mul_valid_fall", {31'd0, out_valid}, 32'd0);
    check_eq("mul_res_hold", alu_out, 32'h0007_0015);

    // multiply with high product bits, B from immediate
    issue(4'b1110, 32'hFFFF_FFFF, 32'd0, 32'd2, 1'b1);
    wait_mul(bc, 1'b0, 32'd0);
    check_eq("mul2_valid", {31'd0, out_valid}, 32'd1);
    check_eq("mul2_res", alu_out, 32'hFFFF_FFFE);
    check_ovf("mul2_ovf", 1'b1);
    @(negedge clk);

    // multiply by zero
    issue(4'b1110, 32'h1234_5678, 32'd0, 32'd0, 1'b0);
    wait_mul(bc, 1'b0, 32'd0);
    check_eq("mul0_res", alu_out, 32'd0);
    check_eq("mul0_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);

    // reset in the middle of a multiply
    issue(4'b1110, 32'h0000_0003, 32'h0000_0005, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_alu_out", alu_out, 32'd0);
    check_eq("arst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check_eq("arst_no_stale", stray, 32'd0);
    issue(4'b0011, 32'd1, 32'd2, 32'd0, 1'b0);
    check_eq("or_after_rst", alu_out, 32'd3);
    check_eq("or_after_rst_valid", {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
